sync_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 16 +
 rtl/sync_fifo_ram.sv | 23 ++
 rtl/sync_fifo.sv | 97 +++++++++
 tb/tb_sync_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and read-mode constants for the sync_fifo family.
package fifo_pkg;

   localparam bit FIFO_MODE_SHOWAHEAD  = 1'b1;
   localparam bit FIFO_MODE_REGISTERED = 1'b0;

   // Ceiling log2 with a floor of 1 so a width is never zero.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      if (result < 1) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array: synchronous write, asynchronous read, no reset.
module sync_fifo_ram #(
   parameter int WIDTH  = 140,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, show-ahead or registered read,
// occupancy count, threshold flags, flush and sticky error flags.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 140,
   parameter int FIFO_DEPTH = 4,
   parameter bit SHOW_AHEAD = FIFO_MODE_SHOWAHEAD,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic                                 wren,
   input  logic [FIFO_WIDTH-1:0]                wrdata,
   input  logic                                 rden,
   output logic [FIFO_WIDTH-1:0]                rddata,
   output logic                                 empty,
   output logic                                 full,
   output logic                                 almost_empty,
   output logic                                 almost_full,
   output logic [clog2(FIFO_DEPTH+1)-1:0]       usedw,
   output logic                                 overflow,
   output logic                                 underflow
);

   localparam int CNT_W = clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_we;
   logic [FIFO_WIDTH-1:0] ram_rdata;

   assign empty        = (count == '0);
   assign full         = (count == CNT_MAX);
   assign almost_empty = (32'(count) <= 32'(AE_LEVEL));
   assign almost_full  = (32'(count) >= 32'(AF_LEVEL));
   assign usedw        = count;

   assign wr_acc = wren && !full;
   assign rd_acc = rden && !empty;
   assign ram_we = wr_acc && !rst && !flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Pointers wrap at the true depth so non-power-of-two sizes work.
         if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wren && full)  overflow  <= 1'b1;
         if (rden && empty) underflow <= 1'b1;
      end
   end

   sync_fifo_ram #(
      .WIDTH  (FIFO_WIDTH),
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (wrdata),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   if (SHOW_AHEAD == FIFO_MODE_SHOWAHEAD) begin : g_show_ahead
      // Gate with empty so stale memory is never presented.
      assign rddata = empty ? '0 : ram_rdata;
   end else begin : g_registered
      logic [FIFO_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
         if (rst || flush) rd_q <= '0;
         else if (rd_acc)  rd_q <= ram_rdata;
      end
      assign rddata = rd_q;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Three FIFO configurations driven by shared stimulus, each checked against a
// queue-based model every cycle, plus directed literal checks.
module tb_sync_fifo;

   localparam int W = 32;
   localparam int DEP [3] = '{5, 4, 8};
   localparam int SA  [3] = '{1, 0, 1};
   localparam int AF  [3] = '{4, 3, 6};
   localparam int AE  [3] = '{1, 1, 2};

   logic         clk;
   logic         rst;
   logic         flush;
   logic         wren;
   logic         rden;
   logic [W-1:0] wrdata;

   logic [W-1:0] rd0, rd1, rd2;
   logic         em0, em1, em2, fu0, fu1, fu2;
   logic         ae0, ae1, ae2, af0, af1, af2;
   logic [2:0]   uw0, uw1;
   logic [3:0]   uw2;
   logic         ov0, ov1, ov2, un0, un1, un2;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .SHOW_AHEAD(1'b1)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .wren(wren), .wrdata(wrdata),
      .rden(rden), .rddata(rd0), .empty(em0), .full(fu0),
      .almost_empty(ae0), .almost_full(af0), .usedw(uw0),
      .overflow(ov0), .underflow(un0));

   sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(4), .SHOW_AHEAD(1'b0)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .wren(wren), .wrdata(wrdata),
      .rden(rden), .rddata(rd1), .empty(em1), .full(fu1),
      .almost_empty(ae1), .almost_full(af1), .usedw(uw1),
      .overflow(ov1), .underflow(un1));

   sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .SHOW_AHEAD(1'b1),
               .AF_LEVEL(6), .AE_LEVEL(2)) u2 (
      .clk(clk), .rst(rst), .flush(flush), .wren(wren), .wrdata(wrdata),
      .rden(rden), .rddata(rd2), .empty(em2), .full(fu2),
      .almost_empty(ae2), .almost_full(af2), .usedw(uw2),
      .overflow(ov2), .underflow(un2));

   logic [W-1:0] rd_a [3];
   logic [7:0]   uw_a [3];
   logic [5:0]   fl_a [3];   // {empty, full, almost_empty, almost_full, overflow, underflow}
   assign rd_a[0] = rd0;
   assign rd_a[1] = rd1;
   assign rd_a[2] = rd2;
   assign uw_a[0] = 8'(uw0);
   assign uw_a[1] = 8'(uw1);
   assign uw_a[2] = 8'(uw2);
   assign fl_a[0] = {em0, fu0, ae0, af0, ov0, un0};
   assign fl_a[1] = {em1, fu1, ae1, af1, ov1, un1};
   assign fl_a[2] = {em2, fu2, ae2, af2, ov2, un2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue per instance plus sticky flags and read register.
   logic [W-1:0] mq [3][$];
   bit           m_ovf [3];
   bit           m_unf [3];
   logic [W-1:0] m_rd  [3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int n;
         logic [W-1:0] head;
         n = mq[i].size();
         if (rst || flush) begin
            mq[i].delete();
            m_ovf[i] = 0;
            m_unf[i] = 0;
            m_rd[i]  = '0;
         end else begin
            if (wren && n == DEP[i]) m_ovf[i] = 1;
            if (rden && n == 0)      m_unf[i] = 1;
            if (rden && n > 0) begin
               head = mq[i].pop_front();
               if (SA[i] == 0) m_rd[i] = head;
            end
            if (wren && n < DEP[i]) mq[i].push_back(wrdata);
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            int n;
            logic [W-1:0] exp_rd;
            logic [5:0]   exp_fl;
            n = mq[i].size();
            if (SA[i] == 1) exp_rd = (n == 0) ? '0 : mq[i][0];
            else            exp_rd = m_rd[i];
            exp_fl = {n == 0, n == DEP[i], n <= AE[i], n >= AF[i], m_ovf[i], m_unf[i]};
            check($sformatf("u%0d_rddata", i), longint'(rd_a[i]), longint'(exp_rd));
            check($sformatf("u%0d_usedw", i),  longint'(uw_a[i]), longint'(n));
            check($sformatf("u%0d_flags", i),  longint'(fl_a[i]), longint'(exp_fl));
         end
      end
   end

   task automatic cyc(input logic w, input logic [W-1:0] d, input logic r,
                      input logic f, input logic rs);
      wren = w; wrdata = d; rden = r; flush = f; rst = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc(0, '0, 0, 0, 1);
      cyc(0, '0, 0, 0, 1);
      chk_en = 1;
      check("reset_empty", em0, 1);
      check("reset_rddata", rd0, 0);
      check("reset_usedw", uw0, 0);
      check("reset_ae_af", {ae0, af0, fu0}, 3'b100);

      // Fill depth-5 instance, then one write past full.
      for (int k = 1; k <= 5; k++) cyc(1, W'(k), 0, 0, 0);
      check("fill_full", fu0, 1);
      check("fill_usedw", uw0, 5);
      check("fill_head", rd0, 1);
      cyc(1, 32'h66, 0, 0, 0);
      check("ovf_set", ov0, 1);
      check("ovf_usedw", uw0, 5);

      // Drain in order, then one read past empty.
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("drain_data%0d", k), rd0, k);
         cyc(0, '0, 1, 0, 0);
      end
      check("drain_empty", em0, 1);
      cyc(0, '0, 1, 0, 0);
      check("unf_set", un0, 1);
      check("unf_rddata", rd0, 0);

      // Simultaneous read/write at count 2 across pointer wrap.
      cyc(0, '0, 0, 0, 1);
      cyc(1, 32'h1, 0, 0, 0);
      cyc(1, 32'h2, 0, 0, 0);
      for (int j = 1; j <= 12; j++) begin
         cyc(1, W'(j + 2), 1, 0, 0);
         check($sformatf("wrap_usedw%0d", j), uw0, 2);
         check($sformatf("wrap_head%0d", j), rd0, j + 1);
      end

      // Registered read mode on the depth-4 instance.
      cyc(0, '0, 0, 0, 1);
      cyc(1, 32'hA, 0, 0, 0);
      check("reg_before_read", rd1, 0);
      cyc(0, '0, 1, 0, 0);
      check("reg_after_read", rd1, 32'hA);
      cyc(0, '0, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      check("reg_hold", rd1, 32'hA);

      // Threshold stepping on depth-8 instance.
      cyc(0, '0, 0, 0, 1);
      for (int k = 1; k <= 8; k++) begin
         cyc(1, W'(k), 0, 0, 0);
         check($sformatf("thr_ae_c%0d", k), ae2, (k <= 2) ? 1 : 0);
         check($sformatf("thr_af_c%0d", k), af2, (k >= 6) ? 1 : 0);
      end

      // Flush with concurrent write at count 3 with overflow set.
      cyc(0, '0, 0, 0, 1);
      for (int k = 1; k <= 6; k++) cyc(1, W'(k), 0, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      check("pre_flush_usedw", uw0, 3);
      check("pre_flush_ovf", ov0, 1);
      cyc(1, 32'h77, 0, 1, 0);
      check("flush_usedw", uw0, 0);
      check("flush_empty", em0, 1);
      check("flush_ovf", ov0, 0);
      check("flush_rddata", rd0, 0);

      // Reset mid-burst.
      cyc(1, 32'h10, 0, 0, 0);
      cyc(1, 32'h11, 1, 0, 0);
      cyc(1, 32'h12, 1, 0, 1);
      check("rst_mid_usedw", uw2, 0);
      check("rst_mid_flags", {em2, fu2, ae2, af2, ov2, un2}, 6'b101000);
      check("rst_mid_rd1", rd1, 0);

      // Randomised phase with shifting fill/drain bias.
      for (int c = 0; c < 3000; c++) begin
         int pw, pr;
         case ((c / 150) % 3)
            0:       begin pw = 80; pr = 25; end
            1:       begin pw = 25; pr = 80; end
            default: begin pw = 55; pr = 55; end
         endcase
         cyc($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) == 0, $urandom_range(0, 399) == 0);
      end

      cyc(0, '0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
